alu_share_arb: RTL and testbench

Arbiter/sequencer that time-shares the single combinational ALU between `NREQ` requesters, e.g. the EX stage and a branch-compare or address-generation client. Each requester presents operands and an `alu_op_t` over a valid/ready handshake. The block grants one requester per accept cycle, drives the ALU operand/op ports, and registers the result. It returns the result to the winning requester over a per-requester valid/ready response channel. It sits between the requesters and the ALU instance; the ALU itself stays outside this block.

---
 rtl/mips_pkg.sv | 26 ++
 rtl/alu_arb_pick.sv | 51 +++++
 rtl/alu_share_arb.sv | 108 ++++++++++
 tb/tb_alu_share_arb.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS datapath types: ALU op encoding plus the ALU-share arbiter
// state and sizing constants.
package mips_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_NOR  = 4'd5,
    ALU_SLT  = 4'd6,
    ALU_SLTU = 4'd7,
    ALU_SLL  = 4'd8,
    ALU_SRL  = 4'd9
  } alu_op_t;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_HOLD = 1'b1
  } arb_state_t;

  localparam int unsigned ALU_ARB_MAX_REQ = 8;
  localparam int unsigned ALU_DW          = 32;

endpackage

// File: rtl/alu_arb_pick.sv
// Combinational requester picker: round-robin from ptr when
// ALU_ARB_ROUND_ROBIN_EN is defined, otherwise fixed lowest-index priority.
module alu_arb_pick #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
`ifdef ALU_ARB_ROUND_ROBIN_EN
  input  logic [IW-1:0]   ptr,
`endif
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   win
);

  logic          found;
  logic [IW-1:0] j;

`ifdef ALU_ARB_ROUND_ROBIN_EN
  // Scan a doubled index range starting at ptr so the search wraps circularly.
  always_comb begin
    grant = '0;
    win   = '0;
    found = 1'b0;
    j     = '0;
    for (int unsigned k = 0; k < 2 * NREQ; k++) begin
      j = IW'(k % NREQ);
      if (!found && (k >= 32'(ptr)) && req[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        win      = j;
      end
    end
  end
`else
  always_comb begin
    grant = '0;
    win   = '0;
    found = 1'b0;
    j     = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      j = IW'(i);
      if (!found && req[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        win      = j;
      end
    end
  end
`endif

endmodule

// File: rtl/alu_share_arb.sv
// Time-shares one external combinational ALU between NREQ requesters and
// holds a single registered result slot. Define ALU_ARB_ROUND_ROBIN_EN for
// round-robin arbitration; fixed priority otherwise.
module alu_share_arb
  import mips_pkg::*;
#(
  parameter int unsigned NREQ = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NREQ-1:0]              req_valid,
  output logic [NREQ-1:0]              req_ready,
  input  logic [NREQ-1:0][ALU_DW-1:0]  req_a,
  input  logic [NREQ-1:0][ALU_DW-1:0]  req_b,
  input  alu_op_t [NREQ-1:0]           req_op,
  output logic [NREQ-1:0]              rsp_valid,
  input  logic [NREQ-1:0]              rsp_ready,
  output logic [ALU_DW-1:0]            rsp_data,
  output logic [ALU_DW-1:0]            alu_a,
  output logic [ALU_DW-1:0]            alu_b,
  output alu_op_t                      alu_op,
  input  logic [ALU_DW-1:0]            alu_res
);

  localparam int unsigned IW = $clog2(NREQ);

  arb_state_t       state, state_d;
  logic [IW-1:0]    own, own_d;
  logic [ALU_DW-1:0] rsp_data_d;
  logic [NREQ-1:0]  rsp_valid_d;
  logic [NREQ-1:0]  grant;
  logic [IW-1:0]    win;
  logic             consume, accept;

`ifdef ALU_ARB_ROUND_ROBIN_EN
  logic [IW-1:0]    ptr, ptr_d;
`endif

  alu_arb_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req   (req_valid),
`ifdef ALU_ARB_ROUND_ROBIN_EN
    .ptr   (ptr),
`endif
    .grant (grant),
    .win   (win)
  );

  // Next-state, grant and ALU drive; the slot can refill in the cycle it drains.
  always_comb begin
    state_d     = state;
    own_d       = own;
    rsp_data_d  = rsp_data;
    rsp_valid_d = '0;
    req_ready   = '0;
    alu_a       = '0;
    alu_b       = '0;
    alu_op      = ALU_ADD;
`ifdef ALU_ARB_ROUND_ROBIN_EN
    ptr_d       = ptr;
`endif

    consume = (state == ARB_HOLD) && rsp_ready[own];
    accept  = ((state == ARB_IDLE) || consume) && (|req_valid);

    if (accept) begin
      req_ready  = grant;
      alu_a      = req_a[win];
      alu_b      = req_b[win];
      alu_op     = req_op[win];
      rsp_data_d = alu_res;
      own_d      = win;
      state_d    = ARB_HOLD;
`ifdef ALU_ARB_ROUND_ROBIN_EN
      ptr_d      = (win == IW'(NREQ - 1)) ? '0 : IW'(win + IW'(1));
`endif
    end else if (consume) begin
      state_d = ARB_IDLE;
    end

    if (state_d == ARB_HOLD) begin
      rsp_valid_d[own_d] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ARB_IDLE;
      own       <= '0;
      rsp_data  <= '0;
      rsp_valid <= '0;
`ifdef ALU_ARB_ROUND_ROBIN_EN
      ptr       <= '0;
`endif
    end else begin
      state     <= state_d;
      own       <= own_d;
      rsp_data  <= rsp_data_d;
      rsp_valid <= rsp_valid_d;
`ifdef ALU_ARB_ROUND_ROBIN_EN
      ptr       <= ptr_d;
`endif
    end
  end

endmodule

// File: tb/tb_alu_share_arb.sv
// Self-checking bench for alu_share_arb: vector table, directed corner cases,
// and randomized traffic against a slot-level reference model.
module tb_alu_share_arb;
  import mips_pkg::*;

  localparam int unsigned NREQ = 2;

  logic                        clk;
  logic                        rst_n;
  logic [NREQ-1:0]             req_valid;
  logic [NREQ-1:0]             req_ready;
  logic [NREQ-1:0][31:0]       req_a;
  logic [NREQ-1:0][31:0]       req_b;
  alu_op_t [NREQ-1:0]          req_op;
  logic [NREQ-1:0]             rsp_valid;
  logic [NREQ-1:0]             rsp_ready;
  logic [31:0]                 rsp_data;
  logic [31:0]                 alu_a;
  logic [31:0]                 alu_b;
  alu_op_t                     alu_op;
  logic [31:0]                 alu_res;

  int n_pass = 0;
  int n_tot  = 0;

  alu_share_arb #(.NREQ(NREQ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_op    (alu_op),
    .alu_res   (alu_res)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for the external shared ALU.
  function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input alu_op_t op);
    case (op)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_AND:  return a & b;
      ALU_OR:   return a | b;
      ALU_XOR:  return a ^ b;
      ALU_NOR:  return ~(a | b);
      ALU_SLT:  return {31'd0, $signed(a) < $signed(b)};
      ALU_SLTU: return {31'd0, a < b};
      default:  return 32'd0;
    endcase
  endfunction

  assign alu_res = alu_fn(alu_a, alu_b, alu_op);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req_valid = '0;
    rsp_ready = '0;
    req_a     = '0;
    req_b     = '0;
    for (int i = 0; i < NREQ; i++) req_op[i] = ALU_ADD;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  typedef struct {
    int unsigned r;
    alu_op_t     op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[6];

  // Reference model state
  bit          m_held;
  int unsigned m_own;
  logic [31:0] m_data;
  int unsigned m_ptr;

  initial begin
    logic [NREQ-1:0] exp_rdy;
    logic [NREQ-1:0] exp_vld;
    logic [NREQ-1:0] one;
    int unsigned     w;
    bit              found;
    bit              can;

    one = NREQ'(1);
    tbl[0] = '{r: 0, op: ALU_ADD,  a: 32'd5,          b: 32'd7,          exp: 32'd12};
    tbl[1] = '{r: 1, op: ALU_SUB,  a: 32'd3,          b: 32'd5,          exp: 32'hFFFF_FFFE};
    tbl[2] = '{r: 0, op: ALU_SLT,  a: 32'hFFFF_FFFF,  b: 32'd1,          exp: 32'd1};
    tbl[3] = '{r: 1, op: ALU_SLTU, a: 32'hFFFF_FFFF,  b: 32'd1,          exp: 32'd0};
    tbl[4] = '{r: 0, op: ALU_AND,  a: 32'hF0F0_1234,  b: 32'h0FF0_FF00,  exp: 32'h00F0_1200};
    tbl[5] = '{r: 1, op: ALU_NOR,  a: 32'h0000_FFFF,  b: 32'h00FF_0000,  exp: 32'hFF00_0000};

    do_reset();
    #3;
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_data", rsp_data, 32'd0);
    chk("reset_alu_op", 32'(alu_op), 32'(ALU_ADD));

    // Vector table: one isolated request each, owner always ready
    for (int v = 0; v < 6; v++) begin
      clear_inputs();
      req_valid[tbl[v].r] = 1'b1;
      req_a[tbl[v].r]     = tbl[v].a;
      req_b[tbl[v].r]     = tbl[v].b;
      req_op[tbl[v].r]    = tbl[v].op;
      rsp_ready           = '1;
      #3;
      chk($sformatf("vec%0d_req_ready", v), 32'(req_ready), 32'(one << tbl[v].r));
      chk($sformatf("vec%0d_alu_a", v), alu_a, tbl[v].a);
      tick();
      req_valid = '0;
      #3;
      chk($sformatf("vec%0d_rsp_valid", v), 32'(rsp_valid), 32'(one << tbl[v].r));
      chk($sformatf("vec%0d_rsp_data", v), rsp_data, tbl[v].exp);
      chk($sformatf("vec%0d_idle_alu_a", v), alu_a, 32'd0);
      tick();
      #3;
      chk($sformatf("vec%0d_drained", v), 32'(rsp_valid), 32'd0);
    end

    // Contention: everyone valid every cycle, everyone ready
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      req_a[i] = 32'(i * 10 + 1);
      req_b[i] = 32'(i + 2);
    end
    req_valid = '1;
    rsp_ready = '1;
    w = 0;
    for (int c = 0; c < 6; c++) begin
`ifdef ALU_ARB_ROUND_ROBIN_EN
      w = c % NREQ;
`else
      w = 0;
`endif
      #3;
      chk($sformatf("contend%0d_grant", c), 32'(req_ready), 32'(one << w));
      tick();
      chk($sformatf("contend%0d_data", c), rsp_data, 32'(w * 10 + 1 + w + 2));
      chk($sformatf("contend%0d_valid", c), 32'(rsp_valid), 32'(one << w));
    end
    clear_inputs();
    rsp_ready = '1;
    tick();

    // Backpressure: req1 result held while req0 waits; non-owner ready ignored
    req_valid[1] = 1'b1;
    req_a[1] = 32'd3;
    req_b[1] = 32'd5;
    req_op[1] = ALU_SUB;
    rsp_ready = '0;
    tick();
    req_valid = '0;
    req_valid[0] = 1'b1;
    req_a[0] = 32'd1;
    req_b[0] = 32'd2;
    req_op[0] = ALU_ADD;
    rsp_ready = '0;
    rsp_ready[0] = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #3;
      chk($sformatf("bp%0d_valid", c), 32'(rsp_valid), 32'(one << 1));
      chk($sformatf("bp%0d_data", c), rsp_data, 32'hFFFF_FFFE);
      chk($sformatf("bp%0d_ready", c), 32'(req_ready), 32'd0);
      tick();
    end
    rsp_ready[1] = 1'b1;
    #3;
    chk("bp_consume_accept", 32'(req_ready), 32'(one));
    tick();
    req_valid = '0;
    #3;
    chk("bp_next_valid", 32'(rsp_valid), 32'(one));
    chk("bp_next_data", rsp_data, 32'd3);
    rsp_ready = '1;
    tick();

    // Back-to-back from one requester without a bubble
    clear_inputs();
    rsp_ready[0] = 1'b1;
    req_valid[0] = 1'b1;
    req_a[0] = 32'hFFFF_FFFF;
    req_b[0] = 32'd1;
    req_op[0] = ALU_SLT;
    tick();
    req_op[0] = ALU_SLTU;
    #3;
    chk("b2b_first_data", rsp_data, 32'd1);
    chk("b2b_second_accept", 32'(req_ready), 32'(one));
    tick();
    req_valid = '0;
    #3;
    chk("b2b_second_data", rsp_data, 32'd0);
    chk("b2b_second_valid", 32'(rsp_valid), 32'(one));
    tick();
    #3;
    chk("b2b_idle", 32'(rsp_valid), 32'd0);

    // Reset while holding a result owned by req0
    clear_inputs();
    req_valid[0] = 1'b1;
    req_a[0] = 32'd40;
    req_b[0] = 32'd2;
    tick();
    req_valid = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_hold_valid", 32'(rsp_valid), 32'd0);
    chk("rst_hold_data", rsp_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    req_valid = '1;
    for (int i = 0; i < NREQ; i++) begin
      req_a[i] = 32'(100 + i);
      req_b[i] = 32'd0;
    end
    rsp_ready = '1;
    #1;
    chk("rst_first_grant", 32'(req_ready), 32'(one));
    chk("rst_first_alu_a", alu_a, 32'd100);
    tick();

    // Randomized traffic against the slot model
    do_reset();
    m_held = 0;
    m_own  = 0;
    m_data = '0;
    m_ptr  = 0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        req_valid[i] = ($urandom_range(0, 99) < 60);
        rsp_ready[i] = ($urandom_range(0, 99) < 65);
        req_a[i]     = $urandom;
        req_b[i]     = ($urandom_range(0, 3) == 0) ? req_a[i] : $urandom;
        req_op[i]    = alu_op_t'(4'($urandom_range(0, 7)));
      end
      #3;
      exp_vld = m_held ? (one << m_own) : '0;
      chk($sformatf("rnd%0d_rsp_valid", c), 32'(rsp_valid), 32'(exp_vld));
      if (m_held) chk($sformatf("rnd%0d_rsp_data", c), rsp_data, m_data);

      can   = !m_held || rsp_ready[m_own];
      found = 0;
      w     = 0;
      for (int i = 0; i < NREQ; i++) begin
`ifdef ALU_ARB_ROUND_ROBIN_EN
        int unsigned k;
        k = (m_ptr + i) % NREQ;
`else
        int unsigned k;
        k = i;
`endif
        if (!found && req_valid[k]) begin
          found = 1;
          w = k;
        end
      end
      exp_rdy = (can && found) ? (one << w) : '0;
      chk($sformatf("rnd%0d_req_ready", c), 32'(req_ready), 32'(exp_rdy));

      if (can && found) begin
        m_held = 1;
        m_own  = w;
        m_data = alu_fn(req_a[w], req_b[w], req_op[w]);
        m_ptr  = (w + 1) % NREQ;
      end else if (m_held && rsp_ready[m_own]) begin
        m_held = 0;
      end
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
